// File: rtl/datapath_pkg.sv
// Shared types for the multicycle datapath: ALU opcodes, FSM states, flag bundle.
package datapath_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLT  = 4'd2,
      ALU_SLTU = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9,
      ALU_MUL  = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_MEM,
      S_MUL,
      S_WB
   } dp_state_e;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } dp_flags_t;

endpackage

// File: rtl/datapath_mc_alu.sv
// Combinational ALU plus compare flags derived from a - b.
module dp_alu
   import datapath_pkg::*;
#(
   parameter int NBITS = 8
) (
   input  logic [NBITS-1:0] a_i,
   input  logic [NBITS-1:0] b_i,
   input  alu_op_e          op_i,
   output logic [NBITS-1:0] y_o,
   output dp_flags_t        flags_o
);

   localparam int SW = $clog2(NBITS);

   logic [NBITS:0]   diff;
   logic [SW-1:0]    sh;

   // a + ~b + 1: the top bit is the borrow-free carry (a >= b unsigned)
   assign diff = {1'b0, a_i} + {1'b0, ~b_i} + {{NBITS{1'b0}}, 1'b1};
   assign sh   = b_i[SW-1:0];

   always_comb begin
      flags_o.zero  = (diff[NBITS-1:0] == '0);
      flags_o.neg   = diff[NBITS-1];
      flags_o.carry = diff[NBITS];
      flags_o.ovf   = (a_i[NBITS-1] ^ b_i[NBITS-1])
                    & (diff[NBITS-1] ^ a_i[NBITS-1]);
   end

   always_comb begin
      y_o = a_i + b_i;
      case (op_i)
         ALU_SUB:  y_o = diff[NBITS-1:0];
         ALU_SLT:  y_o = {{(NBITS-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_SLTU: y_o = {{(NBITS-1){1'b0}}, (a_i < b_i)};
         ALU_AND:  y_o = a_i & b_i;
         ALU_OR:   y_o = a_i | b_i;
         ALU_XOR:  y_o = a_i ^ b_i;
         ALU_SLL:  y_o = a_i << sh;
         ALU_SRL:  y_o = a_i >> sh;
         ALU_SRA:  y_o = $unsigned($signed(a_i) >>> sh);
         default:  y_o = a_i + b_i;
      endcase
   end

endmodule

// File: rtl/datapath_mc.sv
// Multicycle datapath: regfile, ALU, memory handshake; FSM IDLE/EXEC/MEM/MUL/WB.
// Define DATAPATH_MUL_EN to build the iterative shift-add multiplier.
module datapath_mc
   import datapath_pkg::*;
#(
   parameter int NBITS      = 8,
   parameter int NREGS      = 32,
   parameter int WIDTH_ALUF = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [$clog2(NREGS)-1:0] RS1,
   input  logic [$clog2(NREGS)-1:0] RS2,
   input  logic [$clog2(NREGS)-1:0] RD,
   input  logic [NBITS-1:0]         IMM,
   input  logic [WIDTH_ALUF-1:0]    ALUControl,
   input  logic                     ALUSrc,
   input  logic                     MemRead,
   input  logic                     MemWrite,
   input  logic                     RegWrite,
   input  logic                     link,
   input  logic [NBITS-1:0]         pclink,
   output logic [NBITS-1:0]         PCReg,
   output logic                     busy,
   output logic                     done,
   output logic                     Zero,
   output logic                     Neg,
   output logic                     Carry,
   output logic                     Overflow,
   output logic                     MemReq,
   output logic                     MemWe,
   output logic [NBITS-3:0]         Address,
   output logic [NBITS-1:0]         WriteData,
   input  logic [NBITS-1:0]         ReadData,
   input  logic                     MemAck
);

   localparam int RW = $clog2(NREGS);

   dp_state_e        state_q, state_d;
   logic [NBITS-1:0] rf_q [NREGS];
   logic [NBITS-1:0] srca_q, srcb_q, wdat_q, alu_q, ld_q, pcl_q;
   logic [RW-1:0]    rd_q;
   alu_op_e          op_q;
   logic             memr_q, memw_q, regw_q, link_q;
   dp_flags_t        flags_q, alu_flags;
   logic [NBITS-1:0] alu_y, wb_data;
   logic             wb_we;

`ifdef DATAPATH_MUL_EN
   localparam int CW = $clog2(NBITS);
   logic [NBITS-1:0] mcand_q, mplier_q;
   logic [CW-1:0]    cnt_q;
   logic             mul_go, mul_last;

   assign mul_go   = (op_q == ALU_MUL) && !(memr_q || memw_q);
   assign mul_last = (cnt_q == CW'(NBITS-1));
`endif

   dp_alu #(.NBITS(NBITS)) u_alu (
      .a_i     (srca_q),
      .b_i     (srcb_q),
      .op_i    (op_q),
      .y_o     (alu_y),
      .flags_o (alu_flags)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_EXEC;
         S_EXEC: begin
            if (memr_q || memw_q) state_d = S_MEM;
`ifdef DATAPATH_MUL_EN
            else if (mul_go) state_d = S_MUL;
`endif
            else state_d = S_WB;
         end
         S_MEM: if (MemAck) state_d = S_WB;
`ifdef DATAPATH_MUL_EN
         S_MUL: if (mul_last) state_d = S_WB;
`endif
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != S_IDLE);
      done   = (state_q == S_WB);
      MemReq = (state_q == S_MEM);
      MemWe  = (state_q == S_MEM) && memw_q;
   end

   // memr_q already excludes stores so a combined command behaves as store only
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         srca_q  <= '0;
         srcb_q  <= '0;
         wdat_q  <= '0;
         pcl_q   <= '0;
         rd_q    <= '0;
         op_q    <= ALU_ADD;
         memr_q  <= 1'b0;
         memw_q  <= 1'b0;
         regw_q  <= 1'b0;
         link_q  <= 1'b0;
         alu_q   <= '0;
         ld_q    <= '0;
         flags_q <= '0;
`ifdef DATAPATH_MUL_EN
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         if (state_q == S_IDLE && start) begin
            srca_q <= rf_q[RS1];
            srcb_q <= ALUSrc ? IMM : rf_q[RS2];
            wdat_q <= rf_q[RS2];
            pcl_q  <= pclink;
            rd_q   <= RD;
            op_q   <= alu_op_e'(ALUControl[3:0]);
            memr_q <= MemRead && !MemWrite;
            memw_q <= MemWrite;
            regw_q <= RegWrite;
            link_q <= link;
         end
         if (state_q == S_EXEC) begin
            alu_q   <= alu_y;
            flags_q <= alu_flags;
`ifdef DATAPATH_MUL_EN
            if (mul_go) begin
               alu_q    <= '0;
               mcand_q  <= srca_q;
               mplier_q <= srcb_q;
               cnt_q    <= '0;
            end
`endif
         end
`ifdef DATAPATH_MUL_EN
         if (state_q == S_MUL) begin
            if (mplier_q[0]) alu_q <= alu_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
         end
`endif
         if (state_q == S_MEM && MemAck && memr_q) ld_q <= ReadData;
      end
   end

   assign wb_data = link_q ? pcl_q : (memr_q ? ld_q : alu_q);
   assign wb_we   = (state_q == S_WB) && regw_q && !memw_q && (rd_q != '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else if (wb_we) begin
         rf_q[rd_q] <= wb_data;
      end
   end

   assign PCReg     = rf_q[RS1];
   assign Address   = alu_q[NBITS-1:2];
   assign WriteData = wdat_q;
   assign Zero      = flags_q.zero;
   assign Neg       = flags_q.neg;
   assign Carry     = flags_q.carry;
   assign Overflow  = flags_q.ovf;

endmodule

// File: tb/tb_datapath_mc.sv
// Directed plus random commands against an arithmetic model of the datapath.
module tb_datapath_mc;

   localparam int N = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [4:0] RS1 = '0, RS2 = '0, RD = '0;
   logic [7:0] IMM = '0, pclink = '0, ReadData = '0;
   logic [3:0] ALUControl = '0;
   logic       ALUSrc = 0, MemRead = 0, MemWrite = 0;
   logic       RegWrite = 0, link = 0, MemAck = 0;
   logic [7:0] PCReg, WriteData;
   logic [5:0] Address;
   logic       busy, done, Zero, Neg, Carry, Overflow, MemReq, MemWe;

   int ncmp = 0;
   int nerr = 0;
   int m [32];

   datapath_mc #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
      .clock(clock), .reset(reset), .start(start),
      .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM),
      .ALUControl(ALUControl), .ALUSrc(ALUSrc),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .link(link), .pclink(pclink),
      .PCReg(PCReg), .busy(busy), .done(done),
      .Zero(Zero), .Neg(Neg), .Carry(Carry), .Overflow(Overflow),
      .MemReq(MemReq), .MemWe(MemWe), .Address(Address),
      .WriteData(WriteData), .ReadData(ReadData), .MemAck(MemAck)
   );

   always #5 clock = ~clock;

   function automatic int sx(int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   function automatic bit is_mul(int op);
`ifdef DATAPATH_MUL_EN
      return op == 10;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int ref_alu(int op, int a, int b);
      int r;
      int sh = b % N;
      case (op)
         1:  r = a - b;
         2:  r = (sx(a) < sx(b)) ? 1 : 0;
         3:  r = (a < b) ? 1 : 0;
         4:  r = a & b;
         5:  r = a | b;
         6:  r = a ^ b;
         7:  r = a * (1 << sh);
         8:  r = a / (1 << sh);
         9:  r = sx(a) >>> sh;
         10: r = is_mul(op) ? a * b : a + b;
         default: r = a + b;
      endcase
      return r & 255;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input int op, rs1, rs2, rd, imm, src,
                          mr, mw, rw, lnk, pcl);
      ALUControl = 4'(op);
      RS1 = 5'(rs1); RS2 = 5'(rs2); RD = 5'(rd);
      IMM = 8'(imm); ALUSrc = src[0];
      MemRead = mr[0]; MemWrite = mw[0];
      RegWrite = rw[0]; link = lnk[0]; pclink = 8'(pcl);
   endtask

   task automatic run(input int op, rs1, rs2, rd, imm, src, mr, mw,
                      rw, lnk, pcl, dly, rdat, poke);
      int a, b, res, lat, exp_lat, memc, fl, wd;
      bit got;
      a   = m[rs1];
      b   = src ? (imm & 255) : m[rs2];
      wd  = m[rs2];
      res = ref_alu(op, a, b);
      exp_lat = (mr || mw) ? dly + 3 : (is_mul(op) ? N + 2 : 2);
      fl = {(((a - b) & 255) == 0), (((a - b) & 255) >= 128), (a >= b),
            ((sx(a) - sx(b)) > 127 || (sx(a) - sx(b)) < -128)};
      @(negedge clock);
      set_cmd(op, rs1, rs2, rd, imm, src, mr, mw, rw, lnk, pcl);
      start = 1'b1;
      @(negedge clock);
      // a competing command held on start for the whole busy period
      if (poke) set_cmd(0, 0, 0, 5, 'h77, 1, 0, 0, 1, 0, 0);
      else start = 1'b0;
      got = 0; lat = 0; memc = 0;
      for (int k = 1; k < 200 && !got; k++) begin
         if (done) begin
            got = 1; lat = k;
         end else begin
            if (MemReq) begin
               memc++;
               chk("addr", Address, (res >> 2) & 63);
               chk("wdata", WriteData, wd);
               chk("memwe", MemWe, mw != 0);
               if (memc == dly + 1) begin
                  MemAck = 1'b1; ReadData = 8'(rdat);
               end else begin
                  MemAck = 1'b0; ReadData = 8'($urandom);
               end
            end else MemAck = 1'b0;
            @(negedge clock);
         end
      end
      MemAck = 1'b0;
      chk("done_seen", got, 1);
      chk("latency", lat, exp_lat);
      chk("flags", {Zero, Neg, Carry, Overflow}, fl);
      if (rw && !mw && rd != 0)
         m[rd] = lnk ? (pcl & 255) : (mr ? (rdat & 255) : res);
      @(negedge clock);
      start = 1'b0;
      chk("done_pulse", done, 0);
      chk("idle", busy, 0);
      RS1 = 5'(rd); #1;
      chk("reg_rd", PCReg, m[rd]);
      if (poke) begin
         RS1 = 5'd5; #1;
         chk("poke_ignored", PCReg, m[5]);
         @(negedge clock);
         chk("poke_no_start", busy, 0);
      end
   endtask

   initial begin
      int op, rs1, rs2, rd, imm, src, kind, mr, mw, lnk;
      foreach (m[i]) m[i] = 0;
      repeat (2) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_mreq", MemReq, 0);
      chk("rst_flags", {Zero, Neg, Carry, Overflow}, 0);
      reset = 1'b1;
      @(negedge clock);
      RS1 = 5'd1; #1;
      chk("rst_r1", PCReg, 0);

      // op rs1 rs2 rd imm src mr mw rw lnk pcl dly rdat poke
      run(0, 0, 0, 1, 5,     1, 0, 0, 1, 0, 0, 0, 0, 0);
      run(0, 1, 0, 2, 'hFD,  1, 0, 0, 1, 0, 0, 0, 0, 0);
      run(1, 1, 1, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0);
      run(0, 0, 0, 1, 'h80,  1, 0, 0, 1, 0, 0, 0, 0, 0);
      run(0, 0, 0, 2, 1,     1, 0, 0, 1, 0, 0, 0, 0, 0);
      run(2, 1, 2, 3, 0,     0, 0, 0, 1, 0, 0, 0, 0, 0);
      run(3, 1, 2, 4, 0,     0, 0, 0, 1, 0, 0, 0, 0, 0);
      run(1, 1, 2, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0);
      run(0, 0, 0, 1, 8,     1, 0, 0, 1, 0, 0, 0, 0, 0);
      run(0, 0, 0, 3, 'hAB,  1, 0, 0, 1, 0, 0, 0, 0, 0);
      run(0, 1, 3, 6, 4,     1, 0, 1, 1, 0, 0, 3, 0, 0);
      run(0, 1, 0, 7, 4,     1, 1, 0, 1, 0, 0, 0, 'hAB, 0);
      run(0, 0, 0, 1, 0,     1, 0, 0, 1, 1, 'h40, 0, 0, 0);
      run(0, 0, 0, 0, 0,     1, 0, 0, 1, 1, 'h55, 0, 0, 0);
      run(0, 3, 3, 6, 0,     1, 1, 1, 1, 0, 0, 2, 'h11, 1);
      run(0, 0, 0, 1, 13,    1, 0, 0, 1, 0, 0, 0, 0, 0);
      run(0, 0, 0, 2, 11,    1, 0, 0, 1, 0, 0, 0, 0, 0);
      run(10, 1, 2, 5, 0,    0, 0, 0, 1, 0, 0, 0, 0, 0);

      // reset pulled in the middle of a pending load
      @(negedge clock);
      set_cmd(0, 1, 0, 7, 0, 1, 1, 0, 1, 0, 0);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      chk("mreq_pre", MemReq, 1);
      #2 reset = 1'b0;
      #1;
      chk("mreq_rst", MemReq, 0);
      chk("busy_rst", busy, 0);
      chk("memwe_rst", MemWe, 0);
      @(negedge clock);
      reset = 1'b1;
      foreach (m[i]) m[i] = 0;
      chk("flags_rst", {Zero, Neg, Carry, Overflow}, 0);
      for (int r = 1; r < 8; r++) begin
         RS1 = 5'(r); #1;
         chk("reg_cleared", PCReg, 0);
      end

      for (int i = 0; i < 40; i++) begin
         op  = $urandom_range(0, 10);
         rs1 = $urandom_range(0, 7);
         rs2 = $urandom_range(0, 7);
         rd  = $urandom_range(0, 7);
         imm = $urandom_range(0, 255);
         src = $urandom_range(0, 1);
         kind = $urandom_range(0, 9);
         mr  = (kind == 0 || kind == 3) ? 1 : 0;
         mw  = (kind == 1 || kind == 3) ? 1 : 0;
         lnk = (kind == 2) ? 1 : 0;
         if ((mr || mw) && op == 10) op = 0;
         run(op, rs1, rs2, rd, imm, src, mr, mw, 1, lnk,
             $urandom_range(0, 255), $urandom_range(0, 3),
             $urandom_range(0, 255), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
